// File: rtl/uc_multiciclo.sv
// -----------------------------------------------------------------------------
// uc_multiciclo
// Multicycle control unit for a 64-bit RV64I-subset datapath (R-type ALU ops,
// ld, sd, beq). It walks each instruction through fetch, decode, execute,
// memory and write-back states. Along the way it drives the datapath enables
// and mux selects, and it waits on instruction/data memory ready handshakes.
// Each wait is bounded by a timeout.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active high
//   opcode       instruction[6:0] from the instruction register
//   funct3       instruction[14:12]
//   funct7_5     instruction[30]
//   alu_flags    ALU flags, bit0 = zero (beq taken when set)
//   i_mem_ready  instruction word valid this cycle
//   d_mem_ready  data memory access completes this cycle
//   ir_we        load instruction register
//   pc_we        update PC
//   pc_src       0: PC+4, 1: PC+imm
//   rf_we        register file write enable
//   rf_src       0: ALU result, 1: data memory
//   alu_src      0: register, 1: immediate
//   alu_cmd      0000 and, 0001 or, 0010 add, 0110 sub
//   d_mem_we     data memory write request
//   d_mem_re     data memory read request
//   error        sticky fault (illegal encoding or memory timeout)
//   instret      retired instruction count, wraps modulo 2^CNT_WIDTH
// -----------------------------------------------------------------------------
module uc_multiciclo #(
   parameter int CNT_WIDTH = 32,
   parameter int TIMEOUT   = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [6:0]           opcode,
   input  logic [2:0]           funct3,
   input  logic                 funct7_5,
   input  logic [3:0]           alu_flags,
   input  logic                 i_mem_ready,
   input  logic                 d_mem_ready,
   output logic                 ir_we,
   output logic                 pc_we,
   output logic                 pc_src,
   output logic                 rf_we,
   output logic                 rf_src,
   output logic                 alu_src,
   output logic [3:0]           alu_cmd,
   output logic                 d_mem_we,
   output logic                 d_mem_re,
   output logic                 error,
   output logic [CNT_WIDTH-1:0] instret
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_SD  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_WB_ALU,
      S_ADDR,
      S_MEM_RD,
      S_WB_MEM,
      S_MEM_WR,
      S_BRANCH,
      S_ERROR
   } state_t;

   state_t                state_q, state_d;
   logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
   logic [3:0]            alu_cmd_q, alu_cmd_d;
   logic [CNT_WIDTH-1:0]  instret_q, instret_d;

   logic [WAIT_W-1:0]     wait_cnt_inc;
   logic                  wait_expired;
   logic [3:0]            r_cmd;
   logic                  r_legal;
   logic                  retire;

   // Only the zero flag steers branches; the other flags are not needed here.
   logic                  unused_flags;
   assign unused_flags = ^alu_flags[3:1];

   // A wait times out when this cycle would be the TIMEOUT-th one without ready.
   assign wait_cnt_inc = wait_cnt_q + WAIT_W'(1);
   assign wait_expired = (wait_cnt_inc == WAIT_W'(TIMEOUT));

   // R-type funct decode: only add, sub, and, or are implemented.
   always_comb begin
      r_cmd   = ALU_AND;
      r_legal = 1'b1;
      case ({funct7_5, funct3})
         4'b0_000: r_cmd = ALU_ADD;
         4'b1_000: r_cmd = ALU_SUB;
         4'b0_111: r_cmd = ALU_AND;
         4'b0_110: r_cmd = ALU_OR;
         default:  r_legal = 1'b0;
      endcase
   end

   // Next-state and output decode.
   // NOTE: every signal gets a default at the top so that no path through the
   // case leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = '0;              // leaving or entering any state clears it
      alu_cmd_d  = alu_cmd_q;
      retire     = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = 1'b0;
      rf_we      = 1'b0;
      rf_src     = 1'b0;
      alu_src    = 1'b0;
      alu_cmd    = ALU_AND;
      d_mem_we   = 1'b0;
      d_mem_re   = 1'b0;
      error      = 1'b0;

      case (state_q)
         S_FETCH: begin
            ir_we = i_mem_ready;
            if (i_mem_ready)       state_d = S_DECODE;
            else if (wait_expired) state_d = S_ERROR;
            else                   wait_cnt_d = wait_cnt_inc;
         end

         S_DECODE: begin
            case (opcode)
               OP_R:         state_d = S_EXEC_R;
               OP_LD, OP_SD: state_d = S_ADDR;
               OP_BEQ:       state_d = S_BRANCH;
               default:      state_d = S_ERROR;
            endcase
         end

         S_EXEC_R: begin
            alu_cmd = r_cmd;
            if (r_legal) begin
               alu_cmd_d = r_cmd;   // held for the write-back cycle
               state_d   = S_WB_ALU;
            end else begin
               state_d   = S_ERROR;
            end
         end

         S_WB_ALU: begin
            alu_cmd = alu_cmd_q;
            rf_we   = 1'b1;
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
         end

         S_ADDR: begin
            alu_cmd = ALU_ADD;
            alu_src = 1'b1;
            // The IR is only reloaded in FETCH, so opcode is still ld or sd here.
            state_d = (opcode == OP_LD) ? S_MEM_RD : S_MEM_WR;
         end

         S_MEM_RD: begin
            alu_cmd  = ALU_ADD;
            alu_src  = 1'b1;
            d_mem_re = 1'b1;
            if (d_mem_ready)       state_d = S_WB_MEM;
            else if (wait_expired) state_d = S_ERROR;
            else                   wait_cnt_d = wait_cnt_inc;
         end

         S_WB_MEM: begin
            rf_we   = 1'b1;
            rf_src  = 1'b1;
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
         end

         S_MEM_WR: begin
            alu_cmd  = ALU_ADD;
            alu_src  = 1'b1;
            d_mem_we = 1'b1;
            if (d_mem_ready) begin
               pc_we   = 1'b1;
               retire  = 1'b1;
               state_d = S_FETCH;
            end else if (wait_expired) begin
               state_d = S_ERROR;
            end else begin
               wait_cnt_d = wait_cnt_inc;
            end
         end

         S_BRANCH: begin
            alu_cmd = ALU_SUB;
            pc_we   = 1'b1;
            pc_src  = alu_flags[0];
            retire  = 1'b1;
            state_d = S_FETCH;
         end

         S_ERROR: begin
            error = 1'b1;           // absorbing until reset
         end

         default: begin
            state_d = S_ERROR;
         end
      endcase

      instret_d = retire ? instret_q + CNT_WIDTH'(1) : instret_q;

      // While reset is sampled, nothing may reach the datapath.
      if (rst) begin
         ir_we    = 1'b0;
         pc_we    = 1'b0;
         pc_src   = 1'b0;
         rf_we    = 1'b0;
         rf_src   = 1'b0;
         alu_src  = 1'b0;
         alu_cmd  = ALU_AND;
         d_mem_we = 1'b0;
         d_mem_re = 1'b0;
         error    = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the values from before this edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_FETCH;
         wait_cnt_q <= '0;
         alu_cmd_q  <= ALU_AND;
         instret_q  <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         alu_cmd_q  <= alu_cmd_d;
         instret_q  <= instret_d;
      end
   end

   assign instret = instret_q;

endmodule
